// File: rtl/p2s_arbiter_if.sv
// Requester and shifter-facing signals of the shared P2S arbiter.
interface p2s_arbiter_if #(
    parameter int unsigned DATA_BITS = 64
);
    logic                 req0;
    logic                 req1;
    logic [DATA_BITS-1:0] data0;
    logic [DATA_BITS-1:0] data1;
    logic                 done0;
    logic                 done1;
    logic                 err;
    logic                 busy;
    logic                 owner;
    logic                 p2s_start;
    logic [DATA_BITS-1:0] p2s_pdata;
    logic                 p2s_en;

    // Arbiter side
    modport slave (
        input  req0, req1, data0, data1, p2s_en,
        output done0, done1, err, busy, owner, p2s_start, p2s_pdata
    );

    // Requesters plus shifter side
    modport master (
        output req0, req1, data0, data1, p2s_en,
        input  done0, done1, err, busy, owner, p2s_start, p2s_pdata
    );
endinterface

// File: rtl/p2s_arbiter.sv
// Round-robin arbiter sharing one P2S shifter between two requesters,
// with a start watchdog and a mandatory Start-low gap between transfers.
module p2s_arbiter #(
    parameter int unsigned DATA_BITS = 64,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned GAP       = 2
) (
    input  logic         clk,
    input  logic         rstn,
    p2s_arbiter_if.slave bus
);
    localparam int unsigned      CNT_W     = 8;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 owner_q, owner_d;
    logic [DATA_BITS-1:0] pdata_q, pdata_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic                 done0_q, done0_d;
    logic                 done1_q, done1_d;
    logic                 err_q, err_d;
    logic                 winner;

    // A lone request wins; on a tie the requester that did not go last wins
    always_comb begin
        winner = bus.req1;
        if (bus.req0 && bus.req1) begin
            winner = ~owner_q;
        end
    end

    // Next state, shared watchdog/gap counter, and next values of the output registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        pdata_d = pdata_q;
        err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_d = S_GRANT;
                    owner_d = winner;
                    pdata_d = winner ? bus.data1 : bus.data0;
                end
            end
            S_GRANT: begin
                state_d = S_START;
                cnt_d   = '0;
            end
            S_START: begin
                // A shifter that already went busy takes priority over the watchdog
                if (!bus.p2s_en) begin
                    state_d = S_SHIFT;
                end else if (cnt_q == TIMEOUT_C) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                if (bus.p2s_en) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_GAP;
                cnt_d   = '0;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        busy_d  = (state_d != S_IDLE);
        start_d = (state_d == S_START) || (state_d == S_SHIFT);
        done0_d = (state_d == S_DONE) && !owner_d;
        done1_d = (state_d == S_DONE) && owner_d;
    end

    // State and output registers; owner resets to 1 so req0 wins the first tie
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b1;
            pdata_q <= '0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            pdata_q <= pdata_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err_q   <= err_d;
        end
    end

    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.p2s_start = start_q;
    assign bus.p2s_pdata = pdata_q;
endmodule

// File: tb/tb_p2s_arbiter.sv
// Bench for p2s_arbiter: behavioural P2S shifter, timeline model, per-cycle compare.
`timescale 1ns/1ps
module tb_p2s_arbiter;
    localparam int unsigned DB = 64;
    localparam int unsigned TO = 255;
    localparam int unsigned GP = 2;

    localparam logic [63:0] WA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] WB = 64'hFFFF_0000_FFFF_0000;
    localparam logic [63:0] WC = 64'hA5A5_0F0F_1234_8001;
    localparam logic [63:0] WD = 64'h5A5A_F0F0_EDCB_7FFE;
    localparam logic [63:0] WE = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] WF = 64'h1357_9BDF_0246_8ACE;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    p2s_arbiter_if #(.DATA_BITS(DB)) bus();

    p2s_arbiter #(.DATA_BITS(DB), .TIMEOUT(TO), .GAP(GP)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural P2S shifter ----------------
    logic          tie_en = 1'b0;
    logic [1:0]    p_sr   = 2'b00;
    logic [DB-1:0] p_q    = '0;
    logic [DB-1:0] p_col  = '0;
    int            p_cnt  = 0;
    logic [DB-1:0] serq[$];

    // Start edge detector, LSB-first shift, capture of each completed serial word
    always @(posedge clk) begin
        p_sr <= {p_sr[0], bus.p2s_start};
        if (p_sr == 2'b01) begin
            p_q   <= bus.p2s_pdata;
            p_cnt <= int'(DB);
        end else if (p_cnt != 0) begin
            p_q   <= p_q >> 1;
            p_col <= {p_q[0], p_col[DB-1:1]};
            p_cnt <= p_cnt - 1;
            if (p_cnt == 1) serq.push_back({p_q[0], p_col[DB-1:1]});
        end
    end

    assign bus.p2s_en = tie_en ? 1'b1 : (p_cnt == 0);

    // ---------------- timeline model ----------------
    logic          e_busy, e_start, e_done0, e_done1, e_err, e_owner;
    logic [DB-1:0] e_pdata;
    logic          s_req0, s_req1, s_en;
    logic [DB-1:0] s_d0, s_d1;
    logic          m_grants[$];

    task automatic m_clear();
        e_busy  = 1'b0;
        e_start = 1'b0;
        e_done0 = 1'b0;
        e_done1 = 1'b0;
        e_err   = 1'b0;
        e_owner = 1'b1;
        e_pdata = '0;
    endtask

    // Inputs seen at the coming rising edge (they only change just after an edge)
    task automatic m_sample();
        @(negedge clk);
        s_req0 = bus.req0;
        s_req1 = bus.req1;
        s_d0   = bus.data0;
        s_d1   = bus.data1;
        s_en   = bus.p2s_en;
    endtask

    // One arbitration/transfer sequence per loop pass; returns when reset is seen
    task automatic m_run();
        logic w;
        bit   to;
        forever begin
            m_sample();
            @(posedge clk);
            if (rstn !== 1'b1) return;
            if (!(s_req0 || s_req1)) continue;
            w = (s_req0 && s_req1) ? ~e_owner : s_req1;
            m_grants.push_back(w);
            e_owner = w;
            e_pdata = w ? s_d1 : s_d0;
            e_busy  = 1'b1;
            @(posedge clk);
            if (rstn !== 1'b1) return;
            e_start = 1'b1;
            to = 1'b1;
            for (int k = 0; k <= int'(TO); k++) begin
                m_sample();
                @(posedge clk);
                if (rstn !== 1'b1) return;
                if (!s_en) begin
                    to = 1'b0;
                    break;
                end
            end
            if (!to) begin
                for (int k = 0; k < int'(4 * DB); k++) begin
                    m_sample();
                    @(posedge clk);
                    if (rstn !== 1'b1) return;
                    if (s_en) break;
                end
            end
            e_start = 1'b0;
            e_done0 = !w;
            e_done1 = w;
            e_err   = to;
            @(posedge clk);
            if (rstn !== 1'b1) return;
            e_done0 = 1'b0;
            e_done1 = 1'b0;
            e_err   = 1'b0;
            repeat (GP) begin
                @(posedge clk);
                if (rstn !== 1'b1) return;
            end
            e_busy = 1'b0;
        end
    endtask

    initial begin
        forever begin
            m_clear();
            wait (rstn === 1'b1);
            m_run();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rstn !== 1'b1) begin
                chk("rst_busy",  64'(bus.busy),      64'd0);
                chk("rst_start", 64'(bus.p2s_start), 64'd0);
                chk("rst_done0", 64'(bus.done0),     64'd0);
                chk("rst_done1", 64'(bus.done1),     64'd0);
                chk("rst_err",   64'(bus.err),       64'd0);
                chk("rst_owner", 64'(bus.owner),     64'd1);
                chk("rst_pdata", bus.p2s_pdata,      64'd0);
            end else begin
                chk("busy",  64'(bus.busy),      64'(e_busy));
                chk("start", 64'(bus.p2s_start), 64'(e_start));
                chk("done0", 64'(bus.done0),     64'(e_done0));
                chk("done1", 64'(bus.done1),     64'(e_done1));
                chk("err",   64'(bus.err),       64'(e_err));
                chk("owner", 64'(bus.owner),     64'(e_owner));
                chk("pdata", bus.p2s_pdata,      e_pdata);
            end
        end
    end

    // Pulse tallies
    int n_done0 = 0;
    int n_done1 = 0;
    int n_err   = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.done0 === 1'b1) n_done0++;
            if (bus.done1 === 1'b1) n_done1++;
            if (bus.err === 1'b1)   n_err++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drv_edge();
        @(posedge clk);
        #2;
    endtask

    // which: 0 done0, 1 done1, 2 start high, 3 shifter busy
    task automatic wait_sig(input string name, input int which, input int budget);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = (bus.done0 === 1'b1);
                1:       hit = (bus.done1 === 1'b1);
                2:       hit = (bus.p2s_start === 1'b1);
                3:       hit = (bus.p2s_en === 1'b0);
                default: hit = 1'b1;
            endcase
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        bit hit;
        int base;
        logic [63:0] expw[4];
        logic        expg[4];

        expw[0] = WA; expw[1] = WB; expw[2] = WA; expw[3] = WB;
        expg[0] = 1'b0; expg[1] = 1'b1; expg[2] = 1'b0; expg[3] = 1'b1;

        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        bus.data0 = WA;
        bus.data1 = WB;
        tie_en    = 1'b0;
        rstn      = 1'b0;

        // Reset held with both requests high
        repeat (3) @(negedge clk);
        chk("hold_owner", 64'(bus.owner),     64'd1);
        chk("hold_busy",  64'(bus.busy),      64'd0);
        chk("hold_start", 64'(bus.p2s_start), 64'd0);

        // Release: req0 wins the first tie
        drv_edge();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("first_owner", 64'(bus.owner),     64'd0);
        chk("first_pdata", bus.p2s_pdata,      WA);
        chk("first_busy",  64'(bus.busy),      64'd1);
        chk("first_start", 64'(bus.p2s_start), 64'd0);

        // Contention: four alternating transfers
        base = serq.size();
        for (int i = 0; i < 4; i++) begin
            wait_sig($sformatf("cont_done%0d", i), i % 2, 300);
            if (i == 2) begin drv_edge(); bus.req0 = 1'b0; end
            if (i == 3) begin drv_edge(); bus.req1 = 1'b0; end
            @(negedge clk);
            chk("gap_start_a", 64'(bus.p2s_start), 64'd0);
            @(negedge clk);
            chk("gap_start_b", 64'(bus.p2s_start), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            if (m_grants.size() > i) chk($sformatf("grant%0d", i), 64'(m_grants[i]), 64'(expg[i]));
            else chk($sformatf("grant%0d_missing", i), 64'(m_grants.size()), 64'(i + 1));
            if (serq.size() > base + i) chk($sformatf("serial%0d", i), serq[base + i], expw[i]);
            else chk($sformatf("serial%0d_missing", i), 64'(serq.size()), 64'(base + i + 1));
        end
        repeat (5) @(negedge clk);

        // Data stability: requester word changes mid-shift
        base = serq.size();
        drv_edge();
        bus.data0 = WC;
        bus.req0  = 1'b1;
        wait_sig("stab_start", 2, 20);
        wait_sig("stab_shift", 3, 20);
        repeat (10) @(negedge clk);
        drv_edge();
        bus.data0 = WD;
        wait_sig("stab_done0", 0, 200);
        chk("stab_pdata", bus.p2s_pdata, WC);
        chk("stab_err",   64'(bus.err),  64'd0);
        drv_edge();
        bus.req0 = 1'b0;
        if (serq.size() > base) chk("stab_serial", serq[base], WC);
        else chk("stab_serial_missing", 64'(serq.size()), 64'(base + 1));
        repeat (4) @(negedge clk);

        // Watchdog: shifter never reports busy
        drv_edge();
        tie_en    = 1'b1;
        bus.data1 = WE;
        bus.req1  = 1'b1;
        wait_sig("wd_start", 2, 20);
        n   = 0;
        hit = 1'b0;
        while (!hit && n < 400) begin
            @(negedge clk);
            n++;
            hit = (bus.done1 === 1'b1);
        end
        chk("wd_latency", 64'(n),         64'd256);
        chk("wd_err",     64'(bus.err),   64'd1);
        chk("wd_owner",   64'(bus.owner), 64'd1);
        drv_edge();
        bus.req1 = 1'b0;
        tie_en   = 1'b0;
        repeat (4) @(negedge clk);
        chk("wd_idle_busy", 64'(bus.busy), 64'd0);

        // Reset in the middle of a shift, with req1 pending
        drv_edge();
        bus.data0 = WF;
        bus.data1 = WB;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        wait_sig("mid_start", 2, 20);
        chk("mid_owner", 64'(bus.owner), 64'd0);
        wait_sig("mid_shift", 3, 20);
        repeat (20) @(negedge clk);
        drv_edge();
        rstn     = 1'b0;
        bus.req0 = 1'b0;
        @(negedge clk);
        chk("mid_rst_start", 64'(bus.p2s_start), 64'd0);
        chk("mid_rst_busy",  64'(bus.busy),      64'd0);
        chk("mid_rst_done0", 64'(bus.done0),     64'd0);
        repeat (70) @(negedge clk);
        base = serq.size();
        drv_edge();
        rstn = 1'b1;
        wait_sig("post_rst_done1", 1, 300);
        chk("post_rst_owner", 64'(bus.owner), 64'd1);
        chk("post_rst_err",   64'(bus.err),   64'd0);
        drv_edge();
        bus.req1 = 1'b0;
        if (serq.size() > base) chk("post_rst_serial", serq[base], WB);
        else chk("post_rst_serial_missing", 64'(serq.size()), 64'(base + 1));
        repeat (6) @(negedge clk);

        chk("total_done0", 64'(n_done0), 64'd3);
        chk("total_done1", 64'(n_done1), 64'd4);
        chk("total_err",   64'(n_err),   64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/p2s_arbiter.md
# p2s_arbiter

Shares one P2S parallel-to-serial shifter between two requesters (e.g. 7-segment frame and LED frame) with round-robin arbitration. Latches the granted requester's word, drives the shifter's `Start`/`PData`, tracks completion through its `EN` (finish) output, then returns a one-cycle done pulse to the owner. A watchdog recovers if the shifter never starts.

## Interface
Parameters:
- `DATA_BITS`, 64: word width; must match the connected P2S.
- `TIMEOUT`, 255: maximum cycles to wait for `p2s_en` to fall after `Start` is raised; 8-bit counter.
- `GAP`, 2: cycles `p2s_start` is held low after each transfer (≥2).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  level requests; held until the matching done pulse.
- `data0`, `data1`  in  DATA_BITS  words to shift; sampled only at grant.
- `done0`, `done1`  out  1  one-cycle completion pulse for the owner.
- `err`  out  1  one-cycle pulse on watchdog timeout; coincides with the done pulse.
- `busy`  out  1  high from grant through the end of the gap.
- `owner`  out  1  index of the current or last granted requester.
- `p2s_start`  out  1  to P2S `Start`.
- `p2s_pdata`  out  DATA_BITS  to P2S `PData`; registered, stable for the whole transfer.
- `p2s_en`  in  1  from P2S `EN`; high = shifter idle (Q all zero).

## Operation
- States: IDLE, GRANT, START, SHIFT, DONE, GAP.
- IDLE: if any req is high, go to GRANT.
  - If only one req is high, grant it.
  - If both are high, grant the requester that is not `owner`.
- GRANT (1 cycle):
  - `owner` ← winner; `p2s_pdata` ← winner's data; `busy` = 1.
  - Go to START.
- START:
  - `p2s_start` = 1; the watchdog counts up from 0.
  - If `p2s_en` == 0, go to SHIFT.
  - If the watchdog reaches TIMEOUT, set an internal error flag and go to DONE.
- SHIFT:
  - `p2s_start` stays 1.
  - When `p2s_en` == 1, go to DONE.
  - No timeout here; the shifter always finishes in DATA_BITS+1 cycles.
- DONE (1 cycle):
  - `p2s_start` = 0.
  - Pulse `done[owner]`; pulse `err` if the error flag is set, then clear the flag.
  - Go to GAP.
- GAP:
  - `p2s_start` = 0 for GAP cycles, so the P2S edge detector returns to 00 before the next rising edge.
  - Then go to IDLE and deassert `busy`.
- `p2s_pdata` changes only in GRANT. It holds its value after DONE.
- A requester dropping req after its grant does not abort the transfer; done is still pulsed.
- A req that drops before it is granted is ignored.
- Reset (asserted at any time, including mid-transfer):
  - State returns to IDLE; watchdog and error flag cleared.
  - All outputs 0; `owner` = 1, so req0 wins the first tie.
  - The P2S self-recovers once Start is low.

## Timing
- Grant latency: req sampled high in IDLE at edge n → GRANT during cycle n+1 → `p2s_start` high from cycle n+2.
- With a P2S connected, `p2s_en` falls about 3 cycles after `p2s_start` rises. It rises again DATA_BITS cycles later.
- Done pulse is in the cycle after `p2s_en` is sampled high in SHIFT.
- Transfer period, from one grant to the next grant of a waiting requester: 1 + ~3 + DATA_BITS + 1 + GAP + 1 cycles (≈72 for 64 bits).
- Timeout path: done and err fire TIMEOUT+1 cycles after START is entered.
- A new request arriving during DONE or GAP waits until IDLE. The arbitration decision is made from req values sampled in IDLE.

## Test plan
- Reset: hold `rstn`=0 with both req high → all outputs 0, `owner`=1. Release → req0 is granted first, and `p2s_pdata` = data0.
- Single transfer: req0=1, data0=64'h0123_4567_89AB_CDEF, real P2S attached → serial stream LSB-first matches data0. `done0` pulses exactly once, `err`=0, and `p2s_start` low ≥2 cycles afterwards.
- Contention: req0 and req1 held high, data1=64'hFFFF_0000_FFFF_0000 → grants alternate 0,1,0,1. Each done pulse goes to the matching requester, and no two transfers overlap.
- Data stability: change data0 during SHIFT → `p2s_pdata` and the serial output stay at the granted value.
- Watchdog: `p2s_en` tied to 1, req1=1 → `done1` and `err` pulse together 256 cycles after START is entered, then the block returns to IDLE.
- Reset mid-SHIFT: assert `rstn`=0 at bit 20 → `p2s_start`=0 and `busy`=0 immediately, with no done pulse. After release, a pending req1 completes normally.
